// File: rtl/nes_pkg.sv
// nes_pkg: shared constants, DMA state encoding and button bit indices for the 2A03 I/O register block.
package nes_pkg;

    localparam logic [15:0] ADDR_OAMDMA = 16'h4014;
    localparam logic [15:0] ADDR_JOY1   = 16'h4016;
    localparam logic [15:0] ADDR_JOY2   = 16'h4017;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_joy_shift_reg.sv
// nes_joy_shift_reg: serial controller port (parallel load while strobed, shift-on-read with 1-fill).
//   clk, rst_n : clock, async active-low reset (register resets to 8'hFF)
//   en         : cycle qualifier
//   strobe     : latched $4016 bit 0; reload from buttons every enabled cycle while high
//   rd         : CPU read of this port in the current cycle
//   buttons    : live button state, active-high
//   dout       : serial bit presented to the data bus
module nes_joy_shift_reg
    import nes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       strobe,
    input  logic       rd,
    input  logic [7:0] buttons,
    output logic       dout
);

    logic [7:0] sr_q;
    logic [7:0] sr_d;

    // Ones shift in from the top so that reads past the 8th return 1.
    always_comb begin
        sr_d = sr_q;
        if (en)
            sr_d = strobe ? buttons : (rd ? {1'b1, sr_q[7:1]} : sr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr_q <= 8'hFF;
        else
            sr_q <= sr_d;
    end

    // While strobed the port is transparent: the live A button is returned.
    assign dout = strobe ? buttons[BTN_A] : sr_q[0];

endmodule

// File: rtl/nes_cpu_io_regs.sv
// nes_cpu_io_regs: 2A03 on-chip I/O responder for $4014 (OAM DMA), $4016 and $4017 (controllers).
//   CLK, RESET_n         : CPU_CLK domain clock, async active-low reset
//   CPU_ENABLE           : cycle qualifier for all state
//   CPU_ADDR, CPU_RW_n   : resolved bus address / direction (DMA cycles included)
//   CPU_DATA_IN          : resolved data bus (write data, DMA read data)
//   IO_DATA_OUT, IO_rden : controller read data and its bus-mux select
//   CPU_HALT, DMA_ACTIVE : CPU stall and DMA bus ownership
//   DMA_ADDR, DMA_RW_n, DMA_DATA_OUT : DMA bus cycle
//   JOY1_BUTTONS, JOY2_BUTTONS : live button state, active-high
// Optional: define NES_JOY2_EN to build the controller 2 shift register.
module nes_cpu_io_regs
    import nes_pkg::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          DMA_LEN       = 256,
    parameter logic [7:0]  OPEN_BUS_HI   = 8'h40
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        CPU_ENABLE,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_RW_n,
    input  logic [7:0]  CPU_DATA_IN,
    output logic [7:0]  IO_DATA_OUT,
    output logic        IO_rden,
    output logic        CPU_HALT,
    output logic        DMA_ACTIVE,
    output logic [15:0] DMA_ADDR,
    output logic        DMA_RW_n,
    output logic [7:0]  DMA_DATA_OUT,
    input  logic [7:0]  JOY1_BUTTONS,
    input  logic [7:0]  JOY2_BUTTONS
);

    localparam logic [8:0] IDX_LAST = 9'(DMA_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [8:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       strobe_q, strobe_d;
    logic       parity_q, parity_d;

    logic joy1_rd, joy2_rd, strobe_wr, oamdma_wr;
    logic joy1_bit, joy2_bit;

    assign joy1_rd   = CPU_RW_n && (CPU_ADDR == ADDR_JOY1);
    assign joy2_rd   = CPU_RW_n && (CPU_ADDR == ADDR_JOY2);
    assign strobe_wr = !CPU_RW_n && (CPU_ADDR == ADDR_JOY1);
    assign oamdma_wr = !CPU_RW_n && (CPU_ADDR == ADDR_OAMDMA);

    nes_joy_shift_reg u_joy1 (
        .clk     (CLK),
        .rst_n   (RESET_n),
        .en      (CPU_ENABLE),
        .strobe  (strobe_q),
        .rd      (joy1_rd),
        .buttons (JOY1_BUTTONS),
        .dout    (joy1_bit)
    );

`ifdef NES_JOY2_EN
    nes_joy_shift_reg u_joy2 (
        .clk     (CLK),
        .rst_n   (RESET_n),
        .en      (CPU_ENABLE),
        .strobe  (strobe_q),
        .rd      (joy2_rd),
        .buttons (JOY2_BUTTONS),
        .dout    (joy2_bit)
    );
`else
    logic unused_joy2;
    assign unused_joy2 = ^JOY2_BUTTONS;
    assign joy2_bit    = 1'b0;
`endif

    assign IO_rden     = joy1_rd || joy2_rd;
    assign IO_DATA_OUT = OPEN_BUS_HI | {7'b0, joy1_rd ? joy1_bit : (joy2_rd && joy2_bit)};

    // $4017 writes belong to the APU frame counter and are deliberately not decoded.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        parity_d = parity_q;
        if (CPU_ENABLE) begin
            parity_d = ~parity_q;
            if (strobe_wr)
                strobe_d = CPU_DATA_IN[0];
            case (state_q)
                IDLE: begin
                    if (oamdma_wr) begin
                        page_d  = CPU_DATA_IN;
                        idx_d   = '0;
                        state_d = HALT;
                    end
                end
                // An odd cycle needs one extra dummy so READ lands on the get cycle.
                HALT:    state_d = parity_q ? ALIGN : READ;
                ALIGN:   state_d = READ;
                READ: begin
                    data_d  = CPU_DATA_IN;
                    state_d = WRITE;
                end
                WRITE: begin
                    idx_d   = idx_q + 9'd1;
                    state_d = (idx_q == IDX_LAST) ? IDLE : READ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            parity_q <= parity_d;
        end
    end

    assign CPU_HALT     = (state_q != IDLE);
    assign DMA_ACTIVE   = (state_q != IDLE);
    assign DMA_RW_n     = (state_q != WRITE);
    assign DMA_DATA_OUT = data_q;
    assign DMA_ADDR     = (state_q == READ)  ? {page_q, idx_q[7:0]} :
                          (state_q == WRITE) ? OAM_DATA_ADDR : 16'h0000;

endmodule

// File: tb/tb_nes_cpu_io_regs.sv
// tb_nes_cpu_io_regs: directed vector table for the controller path plus DMA, freeze and reset sequences.
module tb_nes_cpu_io_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] tb_addr;
    logic        tb_rw;
    logic [7:0]  tb_data;
    logic [7:0]  joy1, joy2;

    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_data;

    logic [7:0]  io_data_out;
    logic        io_rden, cpu_halt, dma_active, dma_rw_n;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;

    int checks = 0;
    int fails  = 0;
    int halt_cnt, wr_cnt, dummy_cnt, saved;
    logic tb_par;

`ifdef NES_JOY2_EN
    localparam logic [7:0] J2_FIRST = 8'h41;
`else
    localparam logic [7:0] J2_FIRST = 8'h40;
`endif

    always #5 clk = ~clk;

    // Bus model: DMA owns the address bus; memory returns the low address byte.
    assign bus_addr = dma_active ? dma_addr : tb_addr;
    assign bus_rw   = dma_active ? dma_rw_n : tb_rw;
    assign bus_data = dma_active ? dma_addr[7:0] : tb_data;

    nes_cpu_io_regs dut (
        .CLK          (clk),
        .RESET_n      (rst_n),
        .CPU_ENABLE   (en),
        .CPU_ADDR     (bus_addr),
        .CPU_RW_n     (bus_rw),
        .CPU_DATA_IN  (bus_data),
        .IO_DATA_OUT  (io_data_out),
        .IO_rden      (io_rden),
        .CPU_HALT     (cpu_halt),
        .DMA_ACTIVE   (dma_active),
        .DMA_ADDR     (dma_addr),
        .DMA_RW_n     (dma_rw_n),
        .DMA_DATA_OUT (dma_data_out),
        .JOY1_BUTTONS (joy1),
        .JOY2_BUTTONS (joy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        logic [7:0]  j1;
        logic [7:0]  j2;
        logic [7:0]  exp_out;
        logic        exp_rden;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic [15:0] a, input logic rw, input logic [7:0] d,
                       input logic [7:0] j1, input logic [7:0] j2, input logic [7:0] eo, input logic er);
        vec_t v;
        v = '{e, a, rw, d, j1, j2, eo, er};
        vecs.push_back(v);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tb_par <= 1'b0;
        else if (en)
            tb_par <= ~tb_par;
    end

    always @(negedge clk) begin
        if (rst_n && en) begin
            if (cpu_halt)
                halt_cnt++;
            if (cpu_halt && dma_addr == 16'h0000)
                dummy_cnt++;
            if (dma_active && !dma_rw_n) begin
                chk("dma_waddr", 32'(dma_addr), 32'h2004);
                chk("dma_wdata", 32'(dma_data_out), 32'(wr_cnt[7:0]));
                wr_cnt++;
            end
        end
    end

    task automatic start_dma(input logic odd);
        en = 1'b1;
        @(posedge clk); #1;
        if (tb_par == odd) begin
            @(posedge clk); #1;
        end
        halt_cnt  = 0;
        wr_cnt    = 0;
        dummy_cnt = 0;
        tb_addr = 16'h4014; tb_rw = 1'b0; tb_data = 8'h02;
        @(posedge clk); #1;
        tb_addr = 16'h0000; tb_rw = 1'b1; tb_data = 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (dma_active && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dma_done_in_budget", 32'(dma_active), 32'h0);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        halt_cnt = 0; wr_cnt = 0; dummy_cnt = 0;
        rst_n = 1'b0; en = 1'b1;
        tb_addr = 16'h0000; tb_rw = 1'b1; tb_data = 8'h00;
        joy1 = 8'h00; joy2 = 8'h00;

        add(1, 16'h4016, 0, 8'h01, 8'h85, 8'h00, 8'h40, 0);
        add(1, 16'h4016, 0, 8'h00, 8'h85, 8'h00, 8'h40, 0);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h41, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h41, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h41, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h41, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h85, 8'h00, 8'h41, 1);
        add(1, 16'h0000, 1, 8'h00, 8'h85, 8'h00, 8'h40, 0);
        add(1, 16'h4016, 0, 8'h01, 8'h01, 8'h00, 8'h40, 0);
        add(1, 16'h4016, 1, 8'h00, 8'h01, 8'h00, 8'h41, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h00, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h01, 8'h00, 8'h41, 1);
        add(1, 16'h4016, 0, 8'h00, 8'h0A, 8'h00, 8'h40, 0);
        add(1, 16'h4016, 1, 8'h00, 8'h0A, 8'h00, 8'h40, 1);
        add(1, 16'h4017, 0, 8'h01, 8'h0A, 8'h00, 8'h40, 0);
        add(1, 16'h4016, 1, 8'h00, 8'h0A, 8'h00, 8'h41, 1);
        add(0, 16'h4016, 1, 8'h00, 8'h0A, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h0A, 8'h00, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h0A, 8'h00, 8'h41, 1);
        add(1, 16'h4016, 0, 8'h01, 8'h0A, 8'h01, 8'h40, 0);
        add(1, 16'h4016, 0, 8'h00, 8'h0A, 8'h01, 8'h40, 0);
        add(1, 16'h4017, 1, 8'h00, 8'h0A, 8'h01, J2_FIRST, 1);
        add(1, 16'h4017, 1, 8'h00, 8'h0A, 8'h01, 8'h40, 1);
        add(1, 16'h4016, 1, 8'h00, 8'h0A, 8'h01, 8'h40, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_io_data_out", 32'(io_data_out), 32'h40);
        chk("rst_io_rden", 32'(io_rden), 32'h0);
        chk("rst_cpu_halt", 32'(cpu_halt), 32'h0);
        chk("rst_dma_active", 32'(dma_active), 32'h0);
        chk("rst_dma_addr", 32'(dma_addr), 32'h0);
        chk("rst_dma_rw_n", 32'(dma_rw_n), 32'h1);
        chk("rst_dma_data_out", 32'(dma_data_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            en = vecs[i].en; tb_addr = vecs[i].addr; tb_rw = vecs[i].rw;
            tb_data = vecs[i].data; joy1 = vecs[i].j1; joy2 = vecs[i].j2;
            @(negedge clk);
            chk($sformatf("vec%0d_io_data_out", i), 32'(io_data_out), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_io_rden", i), 32'(io_rden), 32'(vecs[i].exp_rden));
        end
        @(posedge clk); #1;
        en = 1'b1; tb_addr = 16'h0000; tb_rw = 1'b1; tb_data = 8'h00;

        start_dma(1'b0);
        wait_idle(1000);
        chk("even_halt_cycles", 32'(halt_cnt), 32'd513);
        chk("even_writes", 32'(wr_cnt), 32'd256);
        chk("even_dummies", 32'(dummy_cnt), 32'd1);

        start_dma(1'b1);
        repeat (50) @(posedge clk);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        wait_idle(1000);
        chk("odd_halt_cycles", 32'(halt_cnt), 32'd514);
        chk("odd_writes", 32'(wr_cnt), 32'd256);
        chk("odd_dummies", 32'(dummy_cnt), 32'd2);

        start_dma(1'b0);
        for (int n = 0; n < 1000 && wr_cnt < 100; n++) begin
            @(posedge clk); #1;
        end
        chk("abort_reached_write100", 32'(wr_cnt), 32'd100);
        rst_n = 1'b0;
        #1;
        chk("abort_cpu_halt", 32'(cpu_halt), 32'h0);
        chk("abort_dma_active", 32'(dma_active), 32'h0);
        chk("abort_dma_addr", 32'(dma_addr), 32'h0);
        chk("abort_dma_rw_n", 32'(dma_rw_n), 32'h1);
        chk("abort_dma_data_out", 32'(dma_data_out), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saved = wr_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_more_writes", 32'(wr_cnt), 32'(saved));
        chk("abort_still_idle", 32'(cpu_halt), 32'h0);

        start_dma(1'b1);
        wait_idle(1000);
        chk("restart_halt_cycles", 32'(halt_cnt), 32'd514);
        chk("restart_writes", 32'(wr_cnt), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
